// File: rtl/micro_sequencer.sv
// Opcode step sequencer: holds IR and the micro-step counter, latches CB-prefix
// opcodes, stalls on memory wait, handles HALT and prioritised interrupt dispatch.
module micro_sequencer #(
  parameter int         STEP_W         = 3,
  parameter int         NUM_IRQ        = 5,
  parameter logic [7:0] VEC_BASE       = 8'h40,
  parameter int         VEC_STRIDE     = 8,
  parameter int         DISPATCH_STEPS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               done,
  input  logic               is_cond,
  input  logic [1:0]         cond,
  input  logic [STEP_W-1:0]  next_cond,
  input  logic [3:0]         flags,
  input  logic               is_prefix,
  input  logic               halt,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [7:0]         d_in,
  output logic [7:0]         ir,
  output logic               ir_prefix,
  output logic [STEP_W-1:0]  step,
  output logic               dispatch,
  output logic [7:0]         irq_vec,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               halted,
  output logic               ime
);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_DISPATCH} state_e;

  state_e              state_q;
  logic [7:0]          ir_q;
  logic                pfx_q;
  logic [STEP_W-1:0]   step_q;
  logic                disp_q;
  logic [7:0]          vec_q;
  logic [NUM_IRQ-1:0]  ack_q;
  logic                halted_q;
  logic                ime_q;
  logic                ime_pend_q;

  logic [NUM_IRQ-1:0]  pend;
  logic [NUM_IRQ-1:0]  sel_ack_d;
  logic [7:0]          sel_vec_d;
  logic                cond_ok;
  logic                take_irq;

  // flags is {z,n,h,c}
  function automatic logic cond_match(input logic [1:0] c, input logic [3:0] f);
    case (c)
      2'b00:   return !f[3];
      2'b01:   return f[3];
      2'b10:   return !f[0];
      default: return f[0];
    endcase
  endfunction

  function automatic logic [7:0] vec_of(input logic [NUM_IRQ-1:0] v);
    logic [7:0] off;
    off = 8'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) off = 8'(i * VEC_STRIDE);
    return VEC_BASE + off;
  endfunction

  assign pend      = irq_req & irq_en;
  assign sel_ack_d = pend & (~pend + NUM_IRQ'(1));
  assign sel_vec_d = vec_of(pend);
  assign cond_ok   = cond_match(cond, flags);
  assign take_irq  = ime_q && (|pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      ir_q       <= 8'h00;
      pfx_q      <= 1'b0;
      step_q     <= '0;
      disp_q     <= 1'b0;
      vec_q      <= VEC_BASE;
      ack_q      <= '0;
      halted_q   <= 1'b0;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
    end else if (stall) begin
      ack_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_RUN: begin
          if (!done) begin
            if (is_cond && !cond_ok) step_q <= next_cond;
            else                     step_q <= step_q + STEP_W'(1);
          end else begin
            if (is_prefix) begin
              ir_q   <= d_in;
              step_q <= '0;
              pfx_q  <= 1'b1;
            end else if (take_irq) begin
              state_q    <= S_DISPATCH;
              step_q     <= '0;
              disp_q     <= 1'b1;
              vec_q      <= sel_vec_d;
              ack_q      <= sel_ack_d;
              ime_q      <= 1'b0;
              ime_pend_q <= 1'b0;
            end else if (halt) begin
              state_q  <= S_HALTED;
              halted_q <= 1'b1;
              step_q   <= '0;
            end else begin
              ir_q   <= d_in;
              step_q <= '0;
              pfx_q  <= 1'b0;
            end
            // EI takes effect one instruction late, so the next one always completes
            if (is_prefix || !take_irq) begin
              if (di) begin
                ime_q      <= 1'b0;
                ime_pend_q <= 1'b0;
              end else if (reti) begin
                ime_q <= 1'b1;
              end else if (ei) begin
                ime_pend_q <= 1'b1;
              end else if (ime_pend_q) begin
                ime_q      <= 1'b1;
                ime_pend_q <= 1'b0;
              end
            end
          end
        end
        S_HALTED: begin
          if (|pend) begin
            halted_q <= 1'b0;
            if (ime_q) begin
              state_q    <= S_DISPATCH;
              step_q     <= '0;
              disp_q     <= 1'b1;
              vec_q      <= sel_vec_d;
              ack_q      <= sel_ack_d;
              ime_q      <= 1'b0;
              ime_pend_q <= 1'b0;
            end else begin
              state_q <= S_RUN;
              ir_q    <= d_in;
              step_q  <= '0;
              pfx_q   <= 1'b0;
            end
          end
        end
        S_DISPATCH: begin
          if (step_q == STEP_W'(DISPATCH_STEPS - 1)) begin
            state_q <= S_RUN;
            ir_q    <= d_in;
            step_q  <= '0;
            pfx_q   <= 1'b0;
            disp_q  <= 1'b0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign ir        = ir_q;
  assign ir_prefix = pfx_q;
  assign step      = step_q;
  assign dispatch  = disp_q;
  assign irq_vec   = vec_q;
  assign irq_ack   = ack_q;
  assign halted    = halted_q;
  assign ime       = ime_q;

endmodule
